token_decoder: RTL

TOKEN_DECODER -- requirements
Module: token_decoder

---
 rtl/tensor_core_pkg.sv | 19 +
 rtl/token_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tensor_core_pkg.sv
// Shared definitions for the token decoder: controller state encoding and
// the character value that separates vocabulary words.
package tensor_core_pkg;

  // Controller states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEEK_RD  = 3'd1,
    S_SEEK_CHK = 3'd2,
    S_EMIT_RD  = 3'd3,
    S_EMIT_CHK = 3'd4,
    S_HOLD     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Word separator stored in the vocabulary memory.
  localparam logic [7:0] NUL_CHAR = 8'h00;

endpackage

// File: rtl/token_decoder.sv
// Token decoder: walks a NUL-separated vocabulary held in an external
// synchronous-read memory, skips to the idx-th word and streams its
// characters (terminating NUL included) over a valid/ready interface.
module token_decoder
  import tensor_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(END_ADDR);
  localparam logic [DATA_WIDTH-1:0] NUL_WORD   = DATA_WIDTH'(NUL_CHAR);

  state_t                  state, state_nx;
  logic [IDX_WIDTH-1:0]    cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]   addr, addr_nx;
  logic [DATA_WIDTH-1:0]   data_nx;
  logic                    last_nx;
  logic                    err_nx;
  logic                    rd_nul;
  logic                    at_end;

  assign mem_addr = addr;
  assign rd_nul   = (mem_rdata == NUL_WORD);
  assign at_end   = (addr == LAST_ADDR);

  // Next-state and datapath decision for the seek / emit walk.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    data_nx  = out_data;
    last_nx  = out_last;
    err_nx   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nx   = idx;
          addr_nx  = FIRST_ADDR;
          err_nx   = 1'b0;
          state_nx = S_SEEK_RD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SEEK_RD: state_nx = S_SEEK_CHK;
      S_SEEK_CHK: begin
        if (cnt == {IDX_WIDTH{1'b0}}) begin
          // First character of the wanted word; a word that starts on the
          // last address cannot continue, so it is closed here too.
          data_nx  = mem_rdata;
          last_nx  = rd_nul || at_end;
          err_nx   = (at_end && !rd_nul) ? 1'b1 : err;
          state_nx = S_HOLD;
        end else begin
          cnt_nx = rd_nul ? (cnt - IDX_WIDTH'(1)) : cnt;
          if (at_end) begin
            err_nx   = 1'b1;
            state_nx = S_DONE;
          end else begin
            addr_nx  = addr + ADDR_WIDTH'(1);
            state_nx = S_SEEK_RD;
          end
        end
      end
      S_EMIT_RD: state_nx = S_EMIT_CHK;
      S_EMIT_CHK: begin
        data_nx  = mem_rdata;
        last_nx  = rd_nul || at_end;
        err_nx   = (at_end && !rd_nul) ? 1'b1 : err;
        state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (out_last) begin
            state_nx = S_DONE;
          end else begin
            addr_nx  = addr + ADDR_WIDTH'(1);
            state_nx = S_EMIT_RD;
          end
        end else begin
          state_nx = S_HOLD;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= {IDX_WIDTH{1'b0}};
      addr      <= FIRST_ADDR;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_last  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      addr      <= addr_nx;
      out_data  <= data_nx;
      out_last  <= last_nx;
      err       <= err_nx;
      busy      <= (state_nx != S_IDLE);
      out_valid <= (state_nx == S_HOLD);
      done      <= (state_nx == S_DONE);
    end
  end

endmodule
